// File: rtl/w5300_receiver_pkg.sv
// Shared W5300 socket-0 register map and receive-FSM types.
// Register addresses are 10-bit direct-mode byte addresses.
package w5300_receiver_pkg;

    localparam logic [9:0] SN_CR       = 10'h202;
    localparam logic [9:0] SN_RX_RSR0  = 10'h228;
    localparam logic [9:0] SN_RX_RSR2  = 10'h22A;
    localparam logic [9:0] SN_RX_FIFOR = 10'h230;
    localparam logic [7:0] SN_CR_RECV  = 8'h40;

    typedef enum logic [3:0] {
        IDLE, RSR_HI, RSR_LO, CHECK, WAIT, LEN, DATA, CMD, DONE
    } w5300_rx_state_t;

    // 17-bit so that a 0xFFFF byte count rounds up to 0x8000 words instead of wrapping
    function automatic logic [16:0] word_count(input logic [15:0] len);
        return ({1'b0, len} + 17'd1) >> 1;
    endfunction

endpackage

// File: rtl/w5300_bus_seq.sv
// Issue-and-wait helper for the shared W5300 bus core: raises op_req only while the core is
// idle, holds addr/op_wr/wr_data until op_state rises again, then pulses done with rd_word.
module w5300_bus_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        wr,
    input  logic [9:0]  req_addr,
    input  logic [15:0] req_data,
    input  logic        op_state,
    input  logic [15:0] rd_data,
    output logic        op_req,
    output logic        op_wr,
    output logic [9:0]  addr,
    output logic [15:0] wr_data,
    output logic        done,
    output logic [15:0] rd_word
);

    logic        busy;
    logic        state_q;
    logic        wr_q;
    logic [9:0]  addr_q;
    logic [15:0] data_q;
    logic [15:0] rd_q;

    assign op_req  = start && !busy && op_state && !rst;
    assign op_wr   = busy ? wr_q : (op_req && wr);
    assign addr    = busy ? addr_q : (op_req ? req_addr : 10'd0);
    assign wr_data = busy ? data_q : ((op_req && wr) ? req_data : 16'd0);
    // Completion is the first rising edge of op_state seen after the request was accepted
    assign done    = busy && !state_q && op_state;
    assign rd_word = done ? rd_data : rd_q;

    always_ff @(posedge clk) begin
        state_q <= op_state;
        if (rst) begin
            busy   <= 1'b0;
            wr_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            rd_q   <= '0;
        end else if (op_req) begin
            busy   <= 1'b1;
            wr_q   <= wr;
            addr_q <= req_addr;
            data_q <= wr ? req_data : 16'd0;
        end else if (done) begin
            busy <= 1'b0;
            rd_q <= rd_data;
        end
    end

endmodule

// File: rtl/w5300_receiver.sv
// W5300 socket receive path: polls RSR, drains one packet from FIFOR into the RX buffer, issues RECV.
// Optional macro W5300_RX_DROP_CNT_EN adds the saturating overflow counter output rx_drop_cnt.
module w5300_receiver
    import w5300_receiver_pkg::*;
#(
    parameter int ETH_RX_BUFFER_WIDTH = 9,
    parameter int POLL_INTERVAL       = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           eth_rx_en,
    output logic [ETH_RX_BUFFER_WIDTH-1:0] eth_rx_buffer_addr,
    output logic [15:0]                    eth_rx_buffer_data,
    output logic                           eth_rx_buffer_wr,
    output logic                           rx_valid,
    output logic [15:0]                    rx_len,
    output logic                           rx_overflow,
    input  logic                           rx_ack,
    output logic [9:0]                     addr,
    output logic [15:0]                    wr_data,
    input  logic [15:0]                    rd_data,
    output logic                           op_req,
    output logic                           op_wr,
    input  logic                           op_state
`ifdef W5300_RX_DROP_CNT_EN
    ,
    output logic [15:0]                    rx_drop_cnt
`endif
);

    localparam logic [16:0] DEPTH     = 17'(2 ** ETH_RX_BUFFER_WIDTH);
    localparam logic [15:0] POLL_LAST = 16'(POLL_INTERVAL - 1);

    w5300_rx_state_t state;
    logic            rsr_hi;
    logic [15:0]     rsr_lo;
    logic [15:0]     len;
    logic [16:0]     words;
    logic [16:0]     idx;
    logic            ovf;
    logic [15:0]     poll_cnt;
    logic            valid_seen;

    logic            start;
    logic            req_wr;
    logic [9:0]      req_addr;
    logic [15:0]     req_data;
    logic            done;
    logic [15:0]     rd_word;

    always_comb begin
        start    = 1'b1;
        req_wr   = 1'b0;
        req_addr = SN_RX_FIFOR;
        req_data = 16'd0;
        case (state)
            RSR_HI:    req_addr = SN_RX_RSR0;
            RSR_LO:    req_addr = SN_RX_RSR2;
            LEN, DATA: req_addr = SN_RX_FIFOR;
            CMD: begin
                req_wr   = 1'b1;
                req_addr = SN_CR;
                req_data = {8'h00, SN_CR_RECV};
            end
            default:   start = 1'b0;
        endcase
    end

    w5300_bus_seq u_bus_seq (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .wr       (req_wr),
        .req_addr (req_addr),
        .req_data (req_data),
        .op_state (op_state),
        .rd_data  (rd_data),
        .op_req   (op_req),
        .op_wr    (op_wr),
        .addr     (addr),
        .wr_data  (wr_data),
        .done     (done),
        .rd_word  (rd_word)
    );

    // Words past the buffer end are still drained from FIFOR but never written
    assign eth_rx_buffer_wr   = (state == DATA) && done && (idx < DEPTH);
    assign eth_rx_buffer_addr = eth_rx_buffer_wr ? idx[ETH_RX_BUFFER_WIDTH-1:0] : '0;
    assign eth_rx_buffer_data = eth_rx_buffer_wr ? rd_word : 16'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rsr_hi      <= 1'b0;
            rsr_lo      <= '0;
            len         <= '0;
            words       <= '0;
            idx         <= '0;
            ovf         <= 1'b0;
            poll_cnt    <= '0;
            valid_seen  <= 1'b0;
            rx_valid    <= 1'b0;
            rx_len      <= '0;
            rx_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: if (eth_rx_en) state <= RSR_HI;
                RSR_HI: if (done) begin
                    rsr_hi <= rd_word[0];
                    state  <= RSR_LO;
                end
                RSR_LO: if (done) begin
                    rsr_lo <= rd_word;
                    state  <= CHECK;
                end
                CHECK: begin
                    poll_cnt <= '0;
                    state    <= ({rsr_hi, rsr_lo} == 17'd0) ? WAIT : LEN;
                end
                WAIT: begin
                    if (poll_cnt == POLL_LAST) state <= IDLE;
                    else poll_cnt <= poll_cnt + 16'd1;
                end
                LEN: if (done) begin
                    len   <= rd_word;
                    words <= word_count(rd_word);
                    idx   <= '0;
                    ovf   <= word_count(rd_word) > DEPTH;
                    state <= (rd_word == 16'd0) ? CMD : DATA;
                end
                DATA: if (done) begin
                    idx <= idx + 17'd1;
                    if (idx + 17'd1 == words) state <= CMD;
                end
                CMD: if (done) begin
                    rx_valid    <= 1'b1;
                    rx_len      <= len;
                    rx_overflow <= ovf;
                    valid_seen  <= 1'b0;
                    state       <= DONE;
                end
                DONE: begin
                    // An ack already high in the first valid cycle is not taken as a release
                    if (valid_seen && rx_ack) begin
                        rx_valid    <= 1'b0;
                        rx_len      <= '0;
                        rx_overflow <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        valid_seen <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef W5300_RX_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) rx_drop_cnt <= '0;
        else if (state == CMD && done && ovf && rx_drop_cnt != 16'hFFFF)
            rx_drop_cnt <= rx_drop_cnt + 16'd1;
    end
`endif

endmodule
